// File: rtl/pattern_serializer_pkg.sv
// ----------------------------------------------------------------------------
// pattern_serializer_pkg
// Shared GPU pattern definitions used by the serializer, the flipper and the
// pattern memory: default pixel depth, default row length and the
// pixel-index type.
// ----------------------------------------------------------------------------
package pattern_serializer_pkg;

    // Bits per pixel and pixels per pattern row at the default configuration.
    localparam int BPP_DEF = 2;
    localparam int PPR_DEF = 8;

    // Row word width at the default configuration.
    localparam int ROW_W_DEF = BPP_DEF * PPR_DEF;

    // Palette index of a single pixel.
    typedef logic [BPP_DEF-1:0] pix_idx_t;

endpackage

// File: rtl/pattern_serializer_if.sv
// ----------------------------------------------------------------------------
// pattern_serializer_if
// Row-in / pixel-out handshake bundle for the pattern serializer.
//   in_valid   : a pattern row is offered
//   in_ready   : serializer accepts a row this cycle
//   in_pattern : packed row, pixel i at [W-1-BPP*i -: BPP]
//   in_hflip   : emit the row right-to-left
//   out_valid  : out_pixel is valid
//   out_ready  : consumer takes out_pixel this cycle
//   out_pixel  : current pixel index
//   out_last   : out_pixel is the final pixel of its row
// The master modport is the producer/consumer side, the slave modport is the
// serializer itself.
// ----------------------------------------------------------------------------
interface pattern_serializer_if
    import pattern_serializer_pkg::*;
#(
    parameter int BPP = BPP_DEF,
    parameter int PPR = PPR_DEF
) ();

    localparam int W = BPP * PPR;

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_pattern;
    logic           in_hflip;
    logic           out_valid;
    logic           out_ready;
    logic [BPP-1:0] out_pixel;
    logic           out_last;

    modport master (
        output in_valid,
        output in_pattern,
        output in_hflip,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_pixel,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_pattern,
        input  in_hflip,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_pixel,
        output out_last
    );

endinterface

// File: rtl/pattern_serializer_row_shifter.sv
// ----------------------------------------------------------------------------
// pattern_row_shifter
// Active row register of the pattern serializer: a shift register holding the
// row being emitted, its pixel counter and its hflip flag.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush_i        : discard the active row
//   load_i         : load loadRow_i / loadHflip_i as the new active row
//   loadRow_i      : packed row to load
//   loadHflip_i    : hflip flag of the row to load
//   ready_i        : consumer takes the current pixel
//   valid_o        : a row is active
//   pixel_o        : current pixel
//   last_o         : current pixel is the last of the row
//   lastHs_o       : last pixel handshakes this cycle (row is being vacated)
// ----------------------------------------------------------------------------
module pattern_row_shifter
    import pattern_serializer_pkg::*;
#(
    parameter int BPP = BPP_DEF,
    parameter int PPR = PPR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 load_i,
    input  logic [BPP*PPR-1:0]   loadRow_i,
    input  logic                 loadHflip_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [BPP-1:0]       pixel_o,
    output logic                 last_o,
    output logic                 lastHs_o
);

    localparam int W  = BPP * PPR;
    localparam int CW = (PPR > 1) ? $clog2(PPR) : 1;

    logic [W-1:0]  row_q,   row_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          hflip_q, hflip_d;
    logic          valid_q, valid_d;

    logic advance;
    logic isLast;

    assign advance  = valid_q && ready_i;
    assign isLast   = valid_q && (cnt_q == CW'(PPR - 1));
    assign lastHs_o = advance && isLast;

    // The row is never reordered on load: a flipped row simply shifts the
    // other way, so the current pixel is always at one end of the register.
    assign valid_o = valid_q;
    assign last_o  = isLast;
    assign pixel_o = hflip_q ? row_q[BPP-1:0] : row_q[W-1 -: BPP];

    // Flush beats load, load beats advance. A load coinciding with the last
    // pixel handshake replaces the row with no empty cycle in between.
    always_comb begin
        row_d   = row_q;
        cnt_d   = cnt_q;
        hflip_d = hflip_q;
        valid_d = valid_q;
        if (flush_i) begin
            row_d   = '0;
            cnt_d   = '0;
            hflip_d = 1'b0;
            valid_d = 1'b0;
        end else if (load_i) begin
            row_d   = loadRow_i;
            cnt_d   = '0;
            hflip_d = loadHflip_i;
            valid_d = 1'b1;
        end else if (advance) begin
            row_d = hflip_q ? (row_q >> BPP) : (row_q << BPP);
            if (isLast) begin
                cnt_d   = '0;
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            cnt_q   <= '0;
            hflip_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            hflip_q <= hflip_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/pattern_serializer.sv
// ----------------------------------------------------------------------------
// pattern_serializer
// Turns packed pattern rows into a pixel stream, one pixel per handshake,
// optionally mirrored. Buffers at most two rows: the active row inside
// pattern_row_shifter and one holding row here.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous discard of all buffered pixels (line start)
//   bus   : row-in / pixel-out handshake (slave side)
// ----------------------------------------------------------------------------
module pattern_serializer
    import pattern_serializer_pkg::*;
#(
    parameter int BPP = BPP_DEF,
    parameter int PPR = PPR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pattern_serializer_if.slave  bus
);

    localparam int W = BPP * PPR;

    logic [W-1:0] holdRow_q,   holdRow_d;
    logic         holdHflip_q, holdHflip_d;
    logic         holdValid_q, holdValid_d;

    logic           shLoad;
    logic [W-1:0]   shRow;
    logic           shHflip;
    logic           actValid;
    logic [BPP-1:0] actPixel;
    logic           actLast;
    logic           actLastHs;

    logic inReady;
    logic xfer;
    logic activeFree;

    // in_ready is low while reset is asserted, so the reset term is included.
    assign inReady    = rst_n && !holdValid_q && !flush;
    assign xfer       = bus.in_valid && inReady;
    assign activeFree = !actValid || actLastHs;

    assign bus.in_ready  = inReady;
    assign bus.out_valid = actValid;
    assign bus.out_pixel = actPixel;
    assign bus.out_last  = actLast;

    // Row routing. The holding row can only be full while the active row is
    // busy, and in_ready is low then, so promotion and a fresh transfer never
    // coincide.
    always_comb begin
        shLoad      = 1'b0;
        shRow       = bus.in_pattern;
        shHflip     = bus.in_hflip;
        holdRow_d   = holdRow_q;
        holdHflip_d = holdHflip_q;
        holdValid_d = holdValid_q;
        if (flush) begin
            holdValid_d = 1'b0;
        end else if (holdValid_q && actLastHs) begin
            shLoad      = 1'b1;
            shRow       = holdRow_q;
            shHflip     = holdHflip_q;
            holdValid_d = 1'b0;
        end else if (xfer && activeFree) begin
            shLoad = 1'b1;
        end else if (xfer) begin
            holdRow_d   = bus.in_pattern;
            holdHflip_d = bus.in_hflip;
            holdValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdRow_q   <= '0;
            holdHflip_q <= 1'b0;
            holdValid_q <= 1'b0;
        end else begin
            holdRow_q   <= holdRow_d;
            holdHflip_q <= holdHflip_d;
            holdValid_q <= holdValid_d;
        end
    end

    pattern_row_shifter #(
        .BPP (BPP),
        .PPR (PPR)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .load_i      (shLoad),
        .loadRow_i   (shRow),
        .loadHflip_i (shHflip),
        .ready_i     (bus.out_ready),
        .valid_o     (actValid),
        .pixel_o     (actPixel),
        .last_o      (actLast),
        .lastHs_o    (actLastHs)
    );

endmodule

// File: tb/tb_pattern_serializer.sv
// ----------------------------------------------------------------------------
// tb_pattern_serializer
// Directed bench for pattern_serializer at BPP=2, PPR=8. Inputs are driven
// and outputs sampled just after the falling clock edge.
// ----------------------------------------------------------------------------
module tb_pattern_serializer;

    typedef struct {
        logic [15:0] pattern;
        logic        hflip;
        logic [15:0] expSeq;   // expected pixels in emission order, first at [15:14]
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;

    int testCount;
    int failCount;

    pattern_serializer_if #(.BPP(2), .PPR(8)) bus ();

    pattern_serializer #(.BPP(2), .PPR(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offer one row while idle with out_ready=1 and check all eight pixels.
    task automatic applyStimulus(input string tag, input logic [15:0] pattern,
                                 input logic hflip, input logic [15:0] expSeq);
        logic [15:0] seq;
        seq = expSeq;
        checkOutput({tag, "_in_ready"}, int'(bus.in_ready), 1);
        bus.in_pattern = pattern;
        bus.in_hflip   = hflip;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s_valid%0d", tag, k), int'(bus.out_valid), 1);
            checkOutput($sformatf("%s_pixel%0d", tag, k), int'(bus.out_pixel), int'(seq[15-2*k -: 2]));
            checkOutput($sformatf("%s_last%0d", tag, k), int'(bus.out_last), (k == 7) ? 1 : 0);
            @(negedge clk);
        end
        checkOutput({tag, "_idle_after"}, int'(bus.out_valid), 0);
    endtask

    vec_t vecs[7];
    int   readyPat[4];

    initial begin
        testCount = 0;
        failCount = 0;

        vecs[0] = '{16'hE41B, 1'b0, 16'hE41B};  // 3,2,1,0,0,1,2,3
        vecs[1] = '{16'hE41B, 1'b1, 16'hE41B};  // mirror of a palindrome row
        vecs[2] = '{16'h06C9, 1'b0, 16'h06C9};  // 0,0,1,2,3,0,2,1
        vecs[3] = '{16'h06C9, 1'b1, 16'h6390};  // 1,2,0,3,2,1,0,0
        vecs[4] = '{16'hFFFF, 1'b0, 16'hFFFF};
        vecs[5] = '{16'h0000, 1'b1, 16'h0000};
        vecs[6] = '{16'h8001, 1'b1, 16'h4002};  // 1,0,0,0,0,0,0,2

        readyPat[0] = 1; readyPat[1] = 0; readyPat[2] = 0; readyPat[3] = 1;

        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_pattern = '0;
        bus.in_hflip   = 1'b0;
        bus.out_ready  = 1'b0;

        // Reset state.
        #3;
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_out_last",  int'(bus.out_last),  0);
        checkOutput("rst_out_pixel", int'(bus.out_pixel), 0);
        checkOutput("rst_in_ready",  int'(bus.in_ready),  0);
        #9 rst_n = 1'b1;
        @(negedge clk);

        // Single rows from the vector table.
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].pattern, vecs[i].hflip, vecs[i].expSeq);
        end

        // Back-to-back rows: no bubble, in_ready low while the holding row is full.
        bus.in_pattern = 16'hFFFF;
        bus.in_hflip   = 1'b0;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                bus.in_pattern = 16'h0000;
                bus.in_valid   = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            checkOutput($sformatf("b2b_valid%0d", k), int'(bus.out_valid), 1);
            checkOutput($sformatf("b2b_pixel%0d", k), int'(bus.out_pixel), (k < 8) ? 3 : 0);
            checkOutput($sformatf("b2b_last%0d", k), int'(bus.out_last), (k == 7 || k == 15) ? 1 : 0);
            checkOutput($sformatf("b2b_in_ready%0d", k), int'(bus.in_ready), (k >= 1 && k <= 7) ? 0 : 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checkOutput("b2b_idle_after", int'(bus.out_valid), 0);

        // Consumer stalls mid-row: pixel holds, none lost or repeated.
        begin
            logic [15:0] seq;
            int idx;
            int cyc;
            logic take;
            seq = 16'h06C9;
            idx = 0;
            cyc = 0;
            bus.in_pattern = 16'h06C9;
            bus.in_hflip   = 1'b0;
            bus.in_valid   = 1'b1;
            bus.out_ready  = 1'b0;
            @(negedge clk);
            bus.in_valid = 1'b0;
            while (idx < 8 && cyc < 40) begin
                checkOutput($sformatf("stall_valid_c%0d", cyc), int'(bus.out_valid), 1);
                checkOutput($sformatf("stall_pixel_c%0d", cyc), int'(bus.out_pixel), int'(seq[15-2*idx -: 2]));
                checkOutput($sformatf("stall_last_c%0d", cyc), int'(bus.out_last), (idx == 7) ? 1 : 0);
                take = readyPat[cyc % 4] != 0;
                bus.out_ready = take;
                @(negedge clk);
                if (take) idx++;
                cyc++;
            end
            checkOutput("stall_all_pixels", idx, 8);
            checkOutput("stall_idle_after", int'(bus.out_valid), 0);
            bus.out_ready = 1'b1;
        end

        // Flush on pixel 3 with the holding row full and a row on offer.
        bus.in_pattern = 16'hE41B;
        bus.in_hflip   = 1'b0;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_pattern = 16'hFFFF;
        @(negedge clk);
        checkOutput("flush_hold_full_ready", int'(bus.in_ready), 0);
        bus.in_pattern = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        checkOutput("flush_pixel3", int'(bus.out_pixel), 0);
        checkOutput("flush_pixel3_valid", int'(bus.out_valid), 1);
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready_low", int'(bus.in_ready), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush_out_valid", int'(bus.out_valid), 0);
        checkOutput("flush_in_ready", int'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_not_accepted", int'(bus.out_valid), 0);

        // Asynchronous reset mid-row, then a fresh row starts from pixel 0.
        bus.in_pattern = 16'h06C9;
        bus.in_hflip   = 1'b0;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("arst_pre_valid", int'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", int'(bus.out_valid), 0);
        checkOutput("arst_out_pixel", int'(bus.out_pixel), 0);
        checkOutput("arst_out_last",  int'(bus.out_last),  0);
        checkOutput("arst_in_ready",  int'(bus.in_ready),  0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arst_still_idle", int'(bus.out_valid), 0);
        applyStimulus("arst_row", 16'h8001, 1'b0, 16'h8001);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 The block SHALL have parameter BPP, default 2, bits per pixel.
REQ-002 The block SHALL have parameter PPR, default 8, pixels per pattern row; row word width W = BPP*PPR (16 at defaults).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of all buffered pixels (line start).
REQ-006 The block SHALL have port in_valid, input, 1, a pattern row is offered.
REQ-007 The block SHALL have port in_ready, output, 1, the block accepts a row this cycle.
REQ-008 The block SHALL have port in_pattern, input, W, packed row; pixel i (left-to-right) at bits [W-1-BPP*i -: BPP].
REQ-009 The block SHALL have port in_hflip, input, 1, emit row right-to-left.
REQ-010 The block SHALL have port out_valid, output, 1, out_pixel is valid.
REQ-011 The block SHALL have port out_ready, input, 1, consumer takes out_pixel this cycle.
REQ-012 The block SHALL have port out_pixel, output, BPP, current pixel index.
REQ-013 The block SHALL have port out_last, output, 1, out_pixel is the final pixel of its row.

Function
REQ-014 The block SHALL hold at most two rows: an active shift register (with 3-bit pixel counter and hflip flag) and one holding register.
REQ-015 in_ready SHALL equal (holding register empty) AND NOT flush; a row transfers when in_valid and in_ready are both high.
REQ-016 A transfer SHALL go to the active register if it is empty or being vacated by its last-pixel handshake this cycle; otherwise it SHALL go to the holding register.
REQ-017 When the active row's last pixel handshakes and the holding register is full, the holding row SHALL move to active in the same cycle; no bubble between rows.
REQ-018 Latency SHALL be one cycle: a row accepted at edge N into an empty active register drives out_valid=1 with its first pixel after edge N.
REQ-019 With in_hflip=0 pixels SHALL emit as in[W-1:W-BPP] first, down to in[BPP-1:0] last; with in_hflip=1 in the reverse order.
REQ-020 The pixel sequence for a row SHALL equal the non-flipped sequence of the bit-pair-reversed row (the horizontal-flip transform).
REQ-021 The active register SHALL advance one pixel only on out_valid AND out_ready; out_pixel SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 out_valid SHALL be 1 iff the active register holds a row; out_last SHALL be 1 iff out_valid and the counter equals PPR-1.
REQ-023 Pixel counter SHALL count 0..PPR-1 and clear when a new row loads; it SHALL never wrap within a row.
REQ-024 flush=1 SHALL empty both registers at the next edge, override any simultaneous transfer or advance, and force in_ready=0 that cycle.
REQ-025 Outputs SHALL depend only on registered state, except in_ready, which is combinational from holding-register state and flush.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear both registers, counter and hflip flags, giving out_valid=0, out_last=0, out_pixel=0, in_ready=0 while reset is asserted.
REQ-027 After rst_n deasserts, in_ready SHALL be 1 from the first cycle; reset mid-row SHALL discard all pending pixels.

Structure
REQ-028 BPP/PPR defaults and the pixel-index typedef SHALL live in the shared GPU package used by the flipper and the pattern memory.
REQ-029 The block SHALL instantiate one sub-module, pattern_row_shifter (active register plus counter); the holding register and handshake logic SHALL stay in the top.

Verification
REQ-030 Reset, then single row 16'hE41B, hflip=0, out_ready=1 -> out_pixel 3,2,1,0,0,1,2,3 on 8 consecutive cycles, out_last on the 8th only.
REQ-031 Same row with hflip=1 -> out_pixel 3,2,1,0,0,1,2,3 reversed per pixel slot (in[1:0] first), matching the flipper's output for 16'hE41B.
REQ-032 Rows 16'hFFFF then 16'h0000 back-to-back, out_ready=1 -> 8 pixels of 3 then 8 of 0, 16 consecutive out_valid cycles, in_ready drops while both registers are full.
REQ-033 out_ready toggled 1,0,0,1,... mid-row -> out_pixel stable across stall cycles, no pixel lost or repeated.
REQ-034 flush asserted on pixel 3 with holding full and in_valid high -> next cycle out_valid=0, in_ready=1, offered row not accepted.
REQ-035 rst_n pulsed low asynchronously mid-row -> out_valid falls without a clock edge; after release, the first accepted row emits from pixel 0.
